// File: rtl/cell_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cell_bank_pkg
//  Description : Shared definitions for the cell bank controller: command
//                opcodes, controller state encoding and the settle counter
//                width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cell_bank_pkg;

    // Command opcodes carried on cmd_op
    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_WRITE   = 3'd1;
    localparam logic [2:0] OP_SET     = 3'd2;
    localparam logic [2:0] OP_CLEAR   = 3'd3;
    localparam logic [2:0] OP_READ    = 3'd4;
    localparam logic [2:0] OP_LAT_ON  = 3'd5;
    localparam logic [2:0] OP_LAT_OFF = 3'd6;
    localparam logic [2:0] OP_ILL     = 3'd7;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    // Width of a down counter that must hold the value SETTLE
    function automatic int settle_cnt_w(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cell_bank_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cell_bank_ctrl_if
//  Description : Command / response bus between a register-access master and
//                the cell bank controller.
//                master : drives cmd_valid/cmd_op/cmd_data, observes
//                         cmd_ready and the rsp_* strobe.
//                slave  : the controller side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cell_bank_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : settle_timer
//  Description : Loadable down counter. load reloads LOAD_VAL, dec counts
//                down (saturating at zero). done is high while the count is
//                one, i.e. in the last cycle of the timed window.
//  Ports       : clk, rst (sync, active high), load, dec -> done
//  Revision    : 1.0 - initial release
// ============================================================================
module settle_timer #(
    parameter int CNT_W    = 2,
    parameter int LOAD_VAL = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic load,
    input  wire logic dec,
    output logic      done
);
    localparam logic [CNT_W-1:0] C_LOAD = LOAD_VAL[CNT_W-1:0];
    localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= C_LOAD;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - C_ONE;
        end
    end

    assign done = (r_cnt == C_ONE);
endmodule
`default_nettype wire

// File: rtl/cell_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cell_bank_ctrl
//  Description : Sequences a bank of WIDTH storage cells from single-beat
//                commands (WRITE/SET/CLEAR/READ/LAT_ON/LAT_OFF). Drive
//                commands pulse the cell pins for one cycle, wait SETTLE
//                cycles, then read the bank back and return a one-cycle
//                response.
//  Ports       : clk, rst          - clock, sync active-high reset
//                bus (slave)       - cmd_valid/ready/op/data, rsp_valid/data/err
//                bank_d/en/sln/sd  - cell data, enable, sync load (low), load value
//                bank_lat          - cell latch-mode select
//                bank_q            - cell outputs
//                busy              - controller not idle
//  Options     : CELL_CHECK_EN - compare readback against the expected value
//                after WRITE/SET/CLEAR and flag a mismatch on rsp_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module cell_bank_ctrl
    import cell_bank_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    cell_bank_ctrl_if.slave       bus,
    output logic [WIDTH-1:0]      bank_d,
    output logic                  bank_en,
    output logic                  bank_sln,
    output logic                  bank_sd,
    output logic                  bank_lat,
    input  wire logic [WIDTH-1:0] bank_q,
    output logic                  busy
);
    localparam int CNT_W = settle_cnt_w(SETTLE);

    state_t           r_state;
    logic [WIDTH-1:0] r_bank_d;
    logic             r_bank_en;
    logic             r_bank_sln;
    logic             r_bank_sd;
    logic             r_bank_lat;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_err;
`ifdef CELL_CHECK_EN
    logic [WIDTH-1:0] r_expected;
`endif

    logic w_timer_load;
    logic w_timer_dec;
    logic w_timer_done;

    // Load at the end of DRIVE so the first SETTLE cycle sees the full count
    assign w_timer_load = (r_state == ST_DRIVE);
    assign w_timer_dec  = (r_state == ST_SETTLE);

    settle_timer #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (SETTLE)
    ) u_settle_timer (
        .clk  (clk),
        .rst  (rst),
        .load (w_timer_load),
        .dec  (w_timer_dec),
        .done (w_timer_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bank_d    <= '0;
            r_bank_en   <= 1'b0;
            r_bank_sln  <= 1'b1;
            r_bank_sd   <= 1'b0;
            r_bank_lat  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
`ifdef CELL_CHECK_EN
            r_expected  <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        case (bus.cmd_op)
                            OP_WRITE: begin
                                r_bank_d  <= bus.cmd_data;
                                r_bank_en <= 1'b1;
`ifdef CELL_CHECK_EN
                                r_expected <= bus.cmd_data;
`endif
                                r_state   <= ST_DRIVE;
                            end
                            OP_SET, OP_CLEAR: begin
                                r_bank_sln <= 1'b0;
                                r_bank_sd  <= (bus.cmd_op == OP_SET);
                                r_bank_en  <= 1'b1;
`ifdef CELL_CHECK_EN
                                r_expected <= {WIDTH{bus.cmd_op == OP_SET}};
`endif
                                r_state    <= ST_DRIVE;
                            end
                            OP_READ, OP_LAT_ON, OP_LAT_OFF, OP_ILL: begin
                                // No cell activity: respond straight away
                                if (bus.cmd_op == OP_LAT_ON) begin
                                    r_bank_lat <= 1'b1;
                                end
                                if (bus.cmd_op == OP_LAT_OFF) begin
                                    r_bank_lat <= 1'b0;
                                end
                                r_rsp_valid <= 1'b1;
                                r_rsp_data  <= bank_q;
                                r_rsp_err   <= (bus.cmd_op == OP_ILL);
                                r_state     <= ST_CHECK;
                            end
                            default: begin
                                // NOP: accepted and dropped
                            end
                        endcase
                    end
                end
                ST_DRIVE: begin
                    // Latch mode keeps the cells transparent through SETTLE
                    r_bank_en  <= r_bank_lat;
                    r_bank_sln <= 1'b1;
                    r_bank_sd  <= 1'b0;
                    r_state    <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (w_timer_done) begin
                        r_bank_en   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= bank_q;
`ifdef CELL_CHECK_EN
                        r_rsp_err   <= (bank_q != r_expected);
`else
                        r_rsp_err   <= 1'b0;
`endif
                        r_state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign busy          = (r_state != ST_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bank_d        = r_bank_d;
    assign bank_en       = r_bank_en;
    assign bank_sln      = r_bank_sln;
    assign bank_sd       = r_bank_sd;
    assign bank_lat      = r_bank_lat;
endmodule
`default_nettype wire

// File: tb/tb_cell_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cell_bank_ctrl
//  Description : Scoreboard bench for cell_bank_ctrl. Commands are issued
//                against a behavioural bank model; the expected response
//                (data, error, arrival cycle, pin activity) is queued at
//                issue time and popped by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_bank_ctrl;
    localparam int W  = 8;
    localparam int ST = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] bank_d;
    logic         bank_en, bank_sln, bank_sd, bank_lat, busy;
    logic [W-1:0] bank_q = '0;
    logic         stuck = 1'b0;

    cell_bank_ctrl_if #(.WIDTH(W)) bus ();

    cell_bank_ctrl #(.WIDTH(W), .SETTLE(ST)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .bank_d   (bank_d),
        .bank_en  (bank_en),
        .bank_sln (bank_sln),
        .bank_sd  (bank_sd),
        .bank_lat (bank_lat),
        .bank_q   (bank_q),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Cell bank: enabled cells capture sd (sync load) or d; bit0 may be stuck at 0
    always @(posedge clk) begin
        if (bank_en)
            bank_q <= (bank_sln ? bank_d : {W{bank_sd}}) & ~{{(W-1){1'b0}}, stuck};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        int           at;
        int           en_n;
        int           sln_n;
        int           sd_n;
        logic         lat;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] mem   = '0;   // reference bank contents
    logic         lat_m = 1'b0; // reference latch-mode flag

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Monitor: accumulate pin activity, compare on each response strobe
    int en_n = 0, sln_n = 0, sd_n = 0;
    always @(negedge clk) begin
        if (rst) begin
            en_n = 0; sln_n = 0; sd_n = 0;
        end else begin
            if (bank_en) en_n++;
            if (!bank_sln) begin
                sln_n++;
                if (bank_sd) sd_n++;
            end
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 want none (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_data",  32'(bus.rsp_data), 32'(e.data));
                    chk("rsp_err",   32'(bus.rsp_err),  32'(e.err));
                    chk("rsp_cycle", cyc,               e.at);
                    chk("en_cycles", en_n,              e.en_n);
                    chk("sln_pulse", sln_n,             e.sln_n);
                    chk("sd_value",  sd_n,              e.sd_n);
                    chk("bank_lat",  32'(bank_lat),     32'(e.lat));
                    chk("busy_chk",  {busy, bus.cmd_ready}, 32'b10);
                end
                en_n = 0; sln_n = 0; sd_n = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] d);
        exp_t         e;
        logic [W-1:0] want;
        bit           drive;
        int           n = 0;
        int           acc;
        @(negedge clk);
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            total++; bad++;
            $display("FAIL ready_timeout: got cmd_ready=0 want 1 (cycle %0d)", cyc);
            return;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom);
        bus.cmd_data  = W'($urandom);
        acc = cyc;

        drive = (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
        case (op)
            3'd1:    want = d;
            3'd2:    want = '1;
            3'd3:    want = '0;
            default: want = mem;
        endcase
        if (drive) mem = want & (stuck ? 8'hFE : 8'hFF);
        if (op == 3'd5) lat_m = 1'b1;
        if (op == 3'd6) lat_m = 1'b0;

        e.data = mem;
        e.err  = (op == 3'd7);
`ifdef CELL_CHECK_EN
        if (drive) e.err = (mem != want);
`endif
        e.lat   = lat_m;
        e.at    = drive ? acc + ST + 1 : acc;
        e.en_n  = drive ? (lat_m ? 1 + ST : 1) : 0;
        e.sln_n = ((op == 3'd2) || (op == 3'd3)) ? 1 : 0;
        e.sd_n  = (op == 3'd2) ? 1 : 0;
        if (op != 3'd0) sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        bus.cmd_valid = 1'b1;   // presented during reset; must be ignored
        bus.cmd_op    = 3'd1;
        bus.cmd_data  = 8'hFF;
        repeat (4) @(negedge clk);
        chk("rst_bank_d",    32'(bank_d), 0);
        chk("rst_ctrl_pins", {bank_en, bank_sln, bank_sd, bank_lat}, 32'b0100);
        chk("rst_rsp",       {bus.rsp_valid, bus.rsp_err, busy}, 0);
        chk("rst_rsp_data",  32'(bus.rsp_data), 0);
        chk("rst_bank_q",    32'(bank_q), 0);
        bus.cmd_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(bus.cmd_ready), 1);

        // Directed sequence
        issue(3'd1, 8'hA5);
        issue(3'd2, 8'h00);
        issue(3'd3, 8'hFF);
        drain();
        stuck = 1'b1;
        issue(3'd1, 8'h01);
        drain();
        stuck = 1'b0;
        issue(3'd5, 8'h00);
        issue(3'd1, 8'h3C);
        issue(3'd6, 8'h00);
        issue(3'd7, 8'h00);
        issue(3'd4, 8'h00);
        issue(3'd0, 8'h12);
        drain();

        // Reset during SETTLE of a WRITE
        issue(3'd1, 8'h5A);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        lat_m = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_ctrl_pins", {bank_en, bank_sln, bank_sd, bank_lat}, 32'b0100);
        chk("abort_rsp",       {bus.rsp_valid, bus.rsp_err, busy}, 0);
        chk("abort_bank_d",    32'(bank_d), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(bus.cmd_ready), 1);
        repeat (4) @(negedge clk);
        issue(3'd4, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            if (lat_m && (op == 3'd2 || op == 3'd3)) op = 3'd1;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(op, W'($urandom));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/cell_bank_ctrl.md
# cell_bank_ctrl

Command-driven controller that sequences a bank of WIDTH configurable storage cells (flip-flop/latch cells with enable, active-low synchronous load, sync data and latch-mode pins). It turns single-beat write/set/clear/read/mode commands into correctly timed cell control pulses. It waits a programmable settle time, then optionally reads the bank back and compares it against the expected value. It sits between a register-access master and the cell bank datapath.

## Interface
Parameters:
- WIDTH, 8, number of cells in the bank
- SETTLE, 2, idle cycles after a drive pulse before readback (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept; high only in IDLE
- cmd_op  in  3  opcode (see Operation)
- cmd_data  in  WIDTH  write data
- bank_d  out  WIDTH  data to cell d pins
- bank_en  out  1  cell enable
- bank_sln  out  1  cell sync load, active low
- bank_sd  out  1  cell sync load value
- bank_lat  out  1  cell latch-mode select
- bank_q  in  WIDTH  cell outputs
- rsp_valid  out  1  one-cycle response strobe
- rsp_data  out  WIDTH  bank_q sampled in CHECK
- rsp_err  out  1  readback mismatch or illegal op, valid with rsp_valid
- busy  out  1  state != IDLE

## Operation
- Opcodes: 0 NOP, 1 WRITE, 2 SET, 3 CLEAR, 4 READ, 5 LAT_ON, 6 LAT_OFF, 7 illegal.
- Accept on cmd_valid && cmd_ready. Opcode and data are captured; inputs are ignored afterwards.
- States: IDLE, DRIVE, SETTLE, CHECK.
- WRITE: IDLE→DRIVE→SETTLE→CHECK→IDLE.
  - DRIVE: bank_d=data, bank_en=1. Expected value = data.
- SET/CLEAR: same path.
  - DRIVE: bank_sln=0, bank_sd=1/0, bank_en=1. Expected value = all ones/all zeros.
- READ: IDLE→CHECK→IDLE. No cell pins toggled; rsp_err=0.
- LAT_ON/LAT_OFF: update the bank_lat register in the accept cycle, then IDLE→CHECK→IDLE with rsp_err=0.
- NOP: acknowledged, no state change, no response.
- Illegal op: IDLE→CHECK; rsp_err=1.
- SETTLE lasts exactly SETTLE cycles, counted by a down counter loaded on entry.
- In latch mode (bank_lat=1), bank_en stays high through DRIVE and all SETTLE cycles (transparent window). Otherwise bank_en is high in DRIVE only.
- bank_d holds its last driven value outside DRIVE.
- CHECK: rsp_valid=1 for one cycle. rsp_data=bank_q. rsp_err per the Configuration section.

## Timing
- Reset values: bank_d=0, bank_en=0, bank_sln=1, bank_sd=0, bank_lat=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0. State=IDLE, so cmd_ready=1 in the first cycle after rst falls.
- Commands presented while rst=1 are not accepted.
- WRITE/SET/CLEAR: accept in cycle T, DRIVE in T+1, SETTLE in T+2..T+SETTLE+1, rsp_valid in T+SETTLE+2. Next accept is possible at T+SETTLE+3.
- READ/LAT/illegal: rsp_valid in T+1.
- rst asserted mid-command: next cycle returns to IDLE, controls inactive, bank_lat=0, no rsp_valid for the aborted command.
- Outputs are registered. cmd_ready and busy are decoded from the state register.

## Configuration
- CELL_CHECK_EN defined: in CHECK after WRITE/SET/CLEAR, rsp_err = (bank_q != expected).
- CELL_CHECK_EN undefined: the comparator and expected register are removed. rsp_err is set only for the illegal op. rsp_data is still returned.

## Structure
- cell_bank_pkg holds:
  - opcode localparams OP_NOP..OP_ILL
  - state encoding ST_IDLE/ST_DRIVE/ST_SETTLE/ST_CHECK
  - width of the settle counter: $clog2(SETTLE+1)
- One sub-module, settle_timer: loadable down counter with a done flag, instanced once.

## Test plan
- Reset, then WRITE 0xA5, SETTLE=2, ideal bank model → bank_en pulse in T+1, rsp_valid at T+4, rsp_data=0xA5, rsp_err=0.
- SET then CLEAR → bank_sln=0 with bank_sd=1/0 for one cycle each; rsp_data=0xFF then 0x00.
- With CELL_CHECK_EN, bank model stuck bit0=0, WRITE 0x01 → rsp_err=1. Without the macro, same stimulus → rsp_err=0.
- LAT_ON then WRITE 0x3C → bank_lat=1 and bank_en high for 3 consecutive cycles (DRIVE + 2 SETTLE); LAT_OFF → bank_lat=0.
- cmd_op=7 → rsp_valid at T+1 with rsp_err=1; READ → rsp_data=bank_q, rsp_err=0.
- rst raised during SETTLE of a WRITE → no rsp_valid, all outputs at reset values next cycle, cmd_ready=1 after release.
